// File: rtl/mole_autoplayer.sv
// Synthetic whack-a-mole player: watches one-hot mole LEDs and presses the
// matching switch after a reaction delay, with an optional deliberate-miss mode.
module mole_autoplayer #(
  parameter int unsigned REACT_CYCLES = 15000000,
  parameter int unsigned HOLD_CYCLES  = 60000000,
  parameter int unsigned MISS_EVERY   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [8:0] leds,
  input  logic       game_over,
  output logic [8:0] switches,
  output logic       busy,
  output logic [7:0] press_count,
  output logic [7:0] miss_count
);

  localparam int unsigned NH       = 9;
  localparam int unsigned TW       = 32;
  localparam int unsigned CW       = 8;
  localparam int unsigned MISS_DIV = (MISS_EVERY == 0) ? 1 : MISS_EVERY;

  typedef enum logic [1:0] {IDLE, REACT, PRESS, WAIT_CHG} state_t;

  state_t          state, state_nx;
  logic [NH-1:0]   tgt, tgt_nx;
  logic [TW-1:0]   timer, timer_nx;
  logic [CW-1:0]   target_count, target_count_nx;
  logic [NH-1:0]   switches_nx;
  logic [CW-1:0]   press_count_nx, miss_count_nx;
  logic            valid, miss;
  logic [NH-1:0]   press_pos;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tgt          <= '0;
      timer        <= '0;
      target_count <= '0;
      switches     <= '0;
      press_count  <= '0;
      miss_count   <= '0;
    end else begin
      state        <= state_nx;
      tgt          <= tgt_nx;
      timer        <= timer_nx;
      target_count <= target_count_nx;
      switches     <= switches_nx;
      press_count  <= press_count_nx;
      miss_count   <= miss_count_nx;
    end
  end

  assign busy = (state != IDLE);

  always_comb begin
    state_nx        = state;
    tgt_nx          = tgt;
    timer_nx        = timer;
    target_count_nx = target_count;
    switches_nx     = switches;
    press_count_nx  = press_count;
    miss_count_nx   = miss_count;

    valid     = (leds != '0) && ((leds & (leds - NH'(1))) == '0);
    miss      = (MISS_EVERY != 0) && ((TW'(target_count) % MISS_DIV) == '0);
    press_pos = miss ? {tgt[NH-2:0], tgt[NH-1]} : tgt;

    // Abort beats every other transition; counters are held.
    if (!enable || game_over) begin
      state_nx    = IDLE;
      switches_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            tgt_nx          = leds;
            timer_nx        = '0;
            target_count_nx = target_count + CW'(1);
            state_nx        = REACT;
          end
        end
        REACT: begin
          // A mole change wins over the terminal count.
          if (leds != tgt) begin
            if (valid) begin
              tgt_nx          = leds;
              timer_nx        = '0;
              target_count_nx = target_count + CW'(1);
            end else begin
              state_nx = IDLE;
            end
          end else if (timer == TW'(REACT_CYCLES - 1)) begin
            state_nx    = PRESS;
            switches_nx = press_pos;
            timer_nx    = '0;
            if (press_count != '1) press_count_nx = press_count + CW'(1);
            if (miss && (miss_count != '1)) miss_count_nx = miss_count + CW'(1);
          end else begin
            timer_nx = timer + TW'(1);
          end
        end
        PRESS: begin
          if (timer == TW'(HOLD_CYCLES - 1)) begin
            switches_nx = '0;
            timer_nx    = '0;
            state_nx    = WAIT_CHG;
          end else begin
            timer_nx = timer + TW'(1);
          end
        end
        WAIT_CHG: begin
          switches_nx = '0;
          if (leds != tgt) state_nx = IDLE;
        end
        default: begin
          state_nx    = IDLE;
          switches_nx = '0;
        end
      endcase
    end
  end

endmodule
